// File: rtl/gray_count_decoder.sv
// Gray-coded sample receiver: decodes each valid Gray word to binary, classifies
// the step against the previous sample, and drops/re-acquires lock on illegal jumps.
module gray_count_decoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned RESYNC = 3,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             up,
  output logic             down,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ref_q;
  logic [CNT_W-1:0] rs_cnt;

  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] delta;
  logic             step_up;
  logic             step_dn;
  logic             legal;
  logic             resync_done;

  // Binary bit i is the XOR of Gray bits i..WIDTH-1.
  always_comb begin
    b_new = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b_new[i] = ^(gray_in >> i);
    end
  end

  always_comb begin
    delta       = b_new - ref_q;
    step_up     = (delta == WIDTH'(1));
    step_dn     = (delta == {WIDTH{1'b1}});
    legal       = (delta == '0) || step_up || step_dn;
    resync_done = ((rs_cnt + CNT_W'(1)) == CNT_W'(RESYNC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ref_q     <= '0;
      rs_cnt    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      err       <= 1'b0;
      if (gray_valid) begin
        ref_q <= b_new;
        case (state)
          IDLE: begin
            bin_out   <= b_new;
            bin_valid <= 1'b1;
            locked    <= 1'b1;
            state     <= TRACK;
          end
          TRACK: begin
            if (legal) begin
              bin_out   <= b_new;
              bin_valid <= 1'b1;
              up        <= step_up;
              down      <= step_dn;
            end else begin
              err    <= 1'b1;
              rs_cnt <= '0;
              locked <= 1'b0;
              state  <= FAULT;
              if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            end
          end
          FAULT: begin
            if (!legal) begin
              err    <= 1'b1;
              rs_cnt <= '0;
              if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
            end else if (resync_done) begin
              // Lock is regained on the sample that completes the clean run.
              rs_cnt    <= '0;
              state     <= TRACK;
              locked    <= 1'b1;
              bin_out   <= b_new;
              bin_valid <= 1'b1;
              up        <= step_up;
              down      <= step_dn;
            end else begin
              rs_cnt <= rs_cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Scoreboard bench for gray_count_decoder: directed samples push expected output
// events; monitors pop and compare whenever the DUTs raise an output pulse.
module tb_gray_count_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = '0;
  logic       gray_valid = 1'b0;

  logic [3:0] bin_out;
  logic       bin_valid, up, down, err, locked;
  logic [7:0] err_count;

  logic [3:0] bin_out2;
  logic       bin_valid2, up2, down2, err2, locked2;
  logic [1:0] err_count2;

  typedef struct packed {
    logic [3:0] bin;
    logic       bv;
    logic       up;
    logic       dn;
    logic       er;
    logic [7:0] ec;
    logic       lk;
  } exp_t;

  exp_t       q[$];
  logic [1:0] q2[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ec      = 0;
  int         ec2     = 0;
  logic [3:0] last_bin = '0;

  gray_count_decoder #(.WIDTH(4), .RESYNC(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out), .bin_valid(bin_valid), .up(up), .down(down),
    .err(err), .err_count(err_count), .locked(locked)
  );

  gray_count_decoder #(.WIDTH(4), .RESYNC(3), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .up(up2), .down(down2),
    .err(err2), .err_count(err_count2), .locked(locked2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bin_valid || up || down || err) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: bv=%0b up=%0b dn=%0b err=%0b at %0t",
                 bin_valid, up, down, err, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bin_out",   int'(bin_out),   int'(e.bin));
        chk("bin_valid", int'(bin_valid), int'(e.bv));
        chk("up",        int'(up),        int'(e.up));
        chk("down",      int'(down),      int'(e.dn));
        chk("err",       int'(err),       int'(e.er));
        chk("err_count", int'(err_count), int'(e.ec));
        chk("locked",    int'(locked),    int'(e.lk));
      end
    end
  end

  always @(negedge clk) begin
    if (err2) begin
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sat_err: err_count=%0d at %0t", err_count2, $time);
      end else begin
        chk("sat_err_count", int'(err_count2), int'(q2.pop_front()));
      end
    end
  end

  // Drive one binary value as Gray; push the expected output event if any.
  task automatic send(input int b, input logic ebv, input logic eup,
                      input logic edn, input logic eer, input logic elk);
    @(posedge clk); #1;
    gray_in    = 4'(b ^ (b >> 1));
    gray_valid = 1'b1;
    if (ebv) last_bin = 4'(b);
    if (eer) begin
      ec  = (ec  == 255) ? 255 : ec + 1;
      ec2 = (ec2 == 3)   ? 3   : ec2 + 1;
      q2.push_back(2'(ec2));
    end
    if (ebv || eup || edn || eer)
      q.push_back('{last_bin, ebv, eup, edn, eer, 8'(ec), elk});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      gray_valid = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bin_out"},   int'(bin_out),    0);
    chk({tag, "_bin_valid"}, int'(bin_valid),  0);
    chk({tag, "_updown"},    int'({up, down}), 0);
    chk({tag, "_err"},       int'(err),        0);
    chk({tag, "_err_count"}, int'(err_count),  0);
    chk({tag, "_locked"},    int'(locked),     0);
    chk({tag, "_sat_count"}, int'(err_count2), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    gray_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ec = 0;
    ec2 = 0;
    last_bin = '0;
    check_zero("reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Count up through the full range and wrap.
    send(0, 1, 0, 0, 0, 1);
    for (int b = 1; b < 16; b++) send(b, 1, 1, 0, 0, 1);
    send(0, 1, 1, 0, 0, 1);
    idle(2);

    // Count down with holds and gaps.
    do_reset();
    send(3, 1, 0, 0, 0, 1);
    idle(2);
    send(2, 1, 0, 1, 0, 1);
    send(2, 1, 0, 0, 0, 1);
    idle(1);
    send(1, 1, 0, 1, 0, 1);
    send(0, 1, 0, 1, 0, 1);
    idle(3);
    send(15, 1, 0, 1, 0, 1);
    idle(2);

    // Illegal jump from 0 to Gray 0100, then re-lock on 8,9,10.
    send(0, 1, 1, 0, 0, 1);
    send(7, 0, 0, 0, 1, 0);
    send(8, 0, 0, 0, 0, 0);
    send(9, 0, 0, 0, 0, 0);
    send(10, 1, 1, 0, 0, 1);
    idle(2);
    chk("relock_level", int'(locked), 1);

    // Broken resync: two clean, illegal, then three clean.
    send(2, 0, 0, 0, 1, 0);
    send(3, 0, 0, 0, 0, 0);
    send(4, 0, 0, 0, 0, 0);
    idle(1);
    chk("fault_locked_a", int'(locked), 0);
    send(12, 0, 0, 0, 1, 0);
    send(13, 0, 0, 0, 0, 0);
    send(14, 0, 0, 0, 0, 0);
    idle(1);
    chk("fault_locked_b", int'(locked), 0);
    send(15, 1, 1, 0, 0, 1);
    idle(2);

    // Saturation: five illegal jumps of delta 7.
    do_reset();
    send(0, 1, 0, 0, 0, 1);
    send(7, 0, 0, 0, 1, 0);
    send(14, 0, 0, 0, 1, 0);
    send(5, 0, 0, 0, 1, 0);
    send(12, 0, 0, 0, 1, 0);
    send(3, 0, 0, 0, 1, 0);
    idle(2);
    chk("sat_final", int'(err_count2), 3);
    chk("main_final", int'(err_count), 5);

    // Reset coincident with a valid sample while tracking.
    do_reset();
    send(5, 1, 0, 0, 0, 1);
    send(6, 1, 1, 0, 0, 1);
    idle(2);
    @(posedge clk); #1;
    rst = 1'b1;
    gray_valid = 1'b1;
    gray_in = 4'b0100;
    @(posedge clk); #1;
    rst = 1'b0;
    gray_valid = 1'b0;
    ec = 0;
    ec2 = 0;
    last_bin = '0;
    check_zero("mid_reset");
    send(9, 1, 0, 0, 0, 1);
    idle(4);

    chk("queue_drained", q.size(), 0);
    chk("sat_queue_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Receiving end of a Gray-coded position/pointer link: samples a Gray word each time the source marks it valid.
- Decodes each accepted word to binary and checks that consecutive samples differ by 0 or ±1 (mod 2^WIDTH).
- Reports step direction, flags illegal jumps, and re-locks after a run of clean samples.
- Sits downstream of any Gray-encoding counter/pointer source; feeds binary consumers such as position logic or FIFO pointer compare.

Parameters:
WIDTH, 4, Gray/binary word width; legal range 2..16.
RESYNC, 3, consecutive clean samples needed in FAULT before returning to TRACK; legal range 1..15.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
gray_in  input  WIDTH  Gray-coded sample.
gray_valid  input  1  gray_in is valid this cycle; one sample per valid cycle, no backpressure.
bin_out  output  WIDTH  binary value of the last accepted sample.
bin_valid  output  1  one-cycle pulse: bin_out updated from an accepted sample.
up  output  1  one-cycle pulse: accepted step was +1 (includes 2^WIDTH-1 -> 0).
down  output  1  one-cycle pulse: accepted step was -1 (includes 0 -> 2^WIDTH-1).
err  output  1  one-cycle pulse: illegal step detected.
err_count  output  ERR_W  number of illegal steps, saturating at 2^ERR_W-1.
locked  output  1  high while state is TRACK.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high.
- On a clk edge with rst=1, all of the following happen regardless of gray_valid:
  - state goes to IDLE;
  - bin_out, bin_valid, up, down, err, err_count and locked go to 0;
  - the internal reference and the resync counter are cleared.
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i], computed combinationally from gray_in.
- Latency: all outputs are registered and appear 1 cycle after the gray_valid cycle. Pulses last exactly 1 cycle. With gray_valid=0, state and reference hold and all pulses are 0.
- Step: delta = (b_new - ref) mod 2^WIDTH.
  - Legal: delta in {0, 1, 2^WIDTH-1}.
  - Illegal: anything else. A single Gray bit flip that is not adjacent, e.g. 0000 -> 0100 (binary delta 7), is illegal.
- States:
  - IDLE, on valid: ref <= b_new; bin_out <= b_new; bin_valid=1; no up/down; go to TRACK with locked=1.
  - TRACK, valid and legal: ref <= b_new; bin_out <= b_new; bin_valid=1.
    - delta=1 pulses up; delta=2^WIDTH-1 pulses down; delta=0 pulses neither.
  - TRACK, valid and illegal: err=1; err_count increments (saturating); ref <= b_new; bin_out holds; bin_valid=0; resync counter=0; go to FAULT with locked=0.
  - FAULT, on valid:
    - ref <= b_new every time; bin_out holds; bin_valid, up and down stay 0.
    - Legal step: resync counter +1. Illegal step: err pulse, err_count +1 (saturating), resync counter resets to 0.
    - When the counter reaches RESYNC: go to TRACK and set locked=1 on that same update. That sample is reported on the same update: bin_out=b_new, bin_valid=1, up/down per its delta.
- err_count at its maximum stays there; err still pulses.
- Reset during FAULT or TRACK discards all history; the next valid sample is treated as the first (IDLE behaviour).

Test Plan:
- Count up: reset, then Gray 0..15..0 (binary 0..15, then 0), one per cycle -> bin_out follows binary with 1-cycle latency; 15 up pulses plus up on the 15->0 wrap; locked=1 from the first sample; err=0.
- Count down with holds: 3,2,2,1,0,15 in binary (sent as Gray), with gaps in gray_valid -> down pulses on 2,1,0,15; no pulse on the repeated 2; bin_valid only in the cycle after each valid sample.
- Illegal jump: TRACK at binary 0, then Gray 0100 -> err pulse, err_count=1, locked=0, bin_out stays 0.
  - Then binary 8,9,10 -> locked rises with bin_out=10 and an up pulse on the third sample.
- Resync broken: in FAULT, send two clean samples, one illegal jump, then three clean -> err_count increments again, counter restarts, lock only after the final three.
- Saturation (ERR_W=2): 5 illegal jumps -> err pulses 5 times; err_count reads 1,2,3,3,3.
- Reset mid-operation: assert rst in the same cycle as gray_valid in TRACK -> next cycle all outputs are 0 and state is IDLE.
  - The next sample of binary 9 gives bin_out=9 with no up/down/err.
